contador_secuencia_ctrl: RTL and testbench
==========================================

// Module: contador_secuencia_ctrl
// PURPOSE
// Sequencing controller for the arbitrary-sequence 4-bit counter 7,13,7,9,6,12,2,8.
// Replaces free-running JK stepping with a start/stop FSM, a clock prescaler and a lap counter.
// Issues done/wrap status to the requester.
// Sits between the control logic (requester) and the display/datapath that consumes Q.
// PARAMETERS
// TICK_DIV  1  clocks per sequence step; legal values 1..255
// LAP_W     4  width of the lap-count request and of the lap counter
// PORTS
// C         in   1      clock; all state changes on posedge C
// R         in   1      reset, asynchronous, active-high
// start     in   1      1-cycle request to begin a run; sampled only in IDLE
// laps      in   LAP_W  laps to run, latched on accepted start; 0 = run until stop
// stop      in   1      abort the run; returns to IDLE
// hold      in   1      pause request (CONTADOR_PAUSE_EN only; otherwise ignored)
// Q         out  4      current sequence value
// idx       out  3      current sequence position, 0..7
// lap_cnt   out  LAP_W  laps completed in the current run
// busy      out  1      1 in RUN or HOLD
// wrap      out  1      1-cycle pulse when idx steps 7->0
// done      out  1      1-cycle pulse when the requested laps complete
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, idx=0, Q=7, lap_cnt=0, prescaler=0, busy=wrap=done=0.
// - Q = ROM[idx], registered with idx. ROM[0..7] = 7,13,7,9,6,12,2,8.
//   Q and idx change in the same cycle.
// - FSM states: IDLE, RUN, HOLD, FIN.
// - IDLE:
//   - start=1 -> latch laps, lap_cnt=0, idx=0, prescaler=0, go to RUN.
//   - busy=1 from the next cycle.
//   - stop is ignored in IDLE, so start wins when start and stop are both 1.
// - RUN:
//   - The prescaler counts 0..TICK_DIV-1. On the terminal count, idx advances by 1 (mod 8).
//   - With TICK_DIV=1, idx advances every clock. The first step comes TICK_DIV clocks after entering RUN.
//   - A step 7->0 produces wrap=1 for that cycle and increments lap_cnt.
//     lap_cnt wraps modulo 2^LAP_W when laps=0.
//   - If laps!=0 and the incremented lap_cnt==laps, go to FIN. idx=0 and Q=7 in that cycle.
//   - stop=1 has priority over stepping:
//     - next cycle: IDLE, idx=0, Q=7, prescaler=0;
//     - lap_cnt keeps its value for readback;
//     - no done pulse, no wrap pulse.
//   - start while busy is ignored, with no effect on laps.
// - FIN: done=1 for exactly one cycle, busy=0, then IDLE. start in FIN is ignored.
// - HOLD (only with the macro): prescaler, idx and lap_cnt are frozen.
//   - hold=0 -> RUN, resuming the prescaler where it stopped.
//   - stop in HOLD -> IDLE, same as stop in RUN.
//   - busy stays 1.
// - wrap and done are never 1 outside the cycles defined above.
//   On the final lap, wrap and done occur in consecutive cycles (wrap, then done in FIN).
// - Reset asserted mid-run returns to IDLE immediately, with no done pulse.
// CONFIGURATION
// - CONTADOR_PAUSE_EN defined:
//   - hold input active. hold=1 in RUN -> HOLD next cycle; the step pending in that cycle is suppressed.
//   - hold has lower priority than stop.
// - CONTADOR_PAUSE_EN undefined:
//   - HOLD state is not built; hold is unconnected internally.
//   - The FSM is only IDLE/RUN/FIN.
// TESTING
// - Reset: R=1 mid-run -> Q=7, idx=0, busy=0, done=0 asynchronously, before the next clock edge.
// - TICK_DIV=1, laps=1, start pulse:
//   - Q=7,13,7,9,6,12,2,8,7 on consecutive cycles;
//   - wrap on the 8->7 step;
//   - done pulse on the next cycle; then busy=0.
// - TICK_DIV=3, laps=2: each Q value held 3 clocks; two wrap pulses; lap_cnt=2; then done.
// - laps=0, stop after 20 steps:
//   - at least 2 wraps, no done;
//   - IDLE with Q=7 and lap_cnt=2.
// - start and stop both asserted in IDLE -> run starts; start during RUN -> no effect on laps or idx.
// - CONTADOR_PAUSE_EN, hold=1 for 5 clocks at Q=9 -> Q stays 9 for those clocks, then continues with 6.

Source files
------------

// File: rtl/contador_secuencia_ctrl_if.sv
// Handshake/status bundle between a requester and contador_secuencia_ctrl.
//   start   : 1-cycle run request (requester -> controller)
//   laps    : number of laps for the run, 0 = run until stop
//   stop    : abort the current run
//   hold    : pause request (used only when CONTADOR_PAUSE_EN is defined)
//   Q       : current sequence value
//   idx     : current sequence position 0..7
//   lap_cnt : laps completed in the current run
//   busy    : run in progress (RUN or HOLD)
//   wrap    : 1-cycle pulse on the idx 7->0 step
//   done    : 1-cycle pulse when the requested laps complete
interface contador_secuencia_ctrl_if #(
  parameter int LAP_W = 4
);
  logic             start;
  logic [LAP_W-1:0] laps;
  logic             stop;
  logic             hold;
  logic [3:0]       Q;
  logic [2:0]       idx;
  logic [LAP_W-1:0] lap_cnt;
  logic             busy;
  logic             wrap;
  logic             done;

  modport master (
    output start, laps, stop, hold,
    input  Q, idx, lap_cnt, busy, wrap, done
  );

  modport slave (
    input  start, laps, stop, hold,
    output Q, idx, lap_cnt, busy, wrap, done
  );
endinterface

// File: rtl/contador_secuencia_ctrl.sv
// Sequencing controller for the 4-bit arbitrary counter 7,13,7,9,6,12,2,8.
// A start/stop FSM steps the sequence position once every TICK_DIV clocks,
// counts completed laps and reports wrap/done status to the requester.
//
// Ports:
//   C   : clock, all state changes on posedge
//   R   : asynchronous active-high reset
//   bus : contador_secuencia_ctrl_if slave modport (start/laps/stop/hold in,
//         Q/idx/lap_cnt/busy/wrap/done out)
//
// Parameters:
//   TICK_DIV : clocks per sequence step, 1..255
//   LAP_W    : width of laps / lap_cnt (must match the interface LAP_W)
//
// Optional feature: define CONTADOR_PAUSE_EN to build the HOLD state and make
// the hold input effective. Without it the FSM is IDLE/RUN/FIN only.
module contador_secuencia_ctrl #(
  parameter int TICK_DIV = 1,
  parameter int LAP_W    = 4
) (
  input  logic                     C,
  input  logic                     R,
  contador_secuencia_ctrl_if.slave bus
);

`ifdef CONTADOR_PAUSE_EN
  typedef enum logic [1:0] {IDLE, RUN, HOLD, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
`endif

  localparam logic [7:0] TC = 8'(TICK_DIV - 1);

  function automatic logic [3:0] rom(input logic [2:0] i);
    rom = 4'd7;
    case (i)
      3'd0: rom = 4'd7;
      3'd1: rom = 4'd13;
      3'd2: rom = 4'd7;
      3'd3: rom = 4'd9;
      3'd4: rom = 4'd6;
      3'd5: rom = 4'd12;
      3'd6: rom = 4'd2;
      3'd7: rom = 4'd8;
      default: rom = 4'd7;
    endcase
  endfunction

  state_t           state_r, state_nxt;
  logic [2:0]       idx_r, idx_nxt;
  logic [3:0]       q_r;
  logic [7:0]       ps_r, ps_nxt;
  logic [LAP_W-1:0] lap_r, lap_nxt;
  logic [LAP_W-1:0] laps_r, laps_nxt;
  logic [LAP_W-1:0] lap_inc;
  logic             wrap;

  always_ff @(posedge C or posedge R) begin
    if (R) state_r <= IDLE;
    else   state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    ps_nxt    = ps_r;
    lap_nxt   = lap_r;
    laps_nxt  = laps_r;
    lap_inc   = lap_r + LAP_W'(1);
    wrap      = 1'b0;
    case (state_r)
      // stop is not looked at here, so a simultaneous start/stop starts a run
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          laps_nxt  = bus.laps;
          lap_nxt   = '0;
          idx_nxt   = 3'd0;
          ps_nxt    = 8'd0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          // lap_cnt is left as-is so the requester can read it back
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
          ps_nxt    = 8'd0;
        end
`ifdef CONTADOR_PAUSE_EN
        else if (bus.hold) begin
          // the step that would have happened this cycle is dropped
          state_nxt = HOLD;
        end
`endif
        else if (ps_r == TC) begin
          ps_nxt  = 8'd0;
          idx_nxt = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            // wrap is combinational so it shows while Q=8; done follows in FIN
            wrap    = 1'b1;
            lap_nxt = lap_inc;
            if ((laps_r != '0) && (lap_inc == laps_r)) state_nxt = FIN;
          end
        end else begin
          ps_nxt = ps_r + 8'd1;
        end
      end
`ifdef CONTADOR_PAUSE_EN
      HOLD: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
          ps_nxt    = 8'd0;
        end else if (!bus.hold) begin
          state_nxt = RUN;
        end
      end
`endif
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Q is registered from the next index so Q and idx always change together
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      idx_r  <= 3'd0;
      q_r    <= 4'd7;
      ps_r   <= 8'd0;
      lap_r  <= '0;
      laps_r <= '0;
    end else begin
      idx_r  <= idx_nxt;
      q_r    <= rom(idx_nxt);
      ps_r   <= ps_nxt;
      lap_r  <= lap_nxt;
      laps_r <= laps_nxt;
    end
  end

  assign bus.Q       = q_r;
  assign bus.idx     = idx_r;
  assign bus.lap_cnt = lap_r;
`ifdef CONTADOR_PAUSE_EN
  assign bus.busy    = (state_r == RUN) || (state_r == HOLD);
`else
  assign bus.busy    = (state_r == RUN);
`endif
  assign bus.wrap    = wrap;
  assign bus.done    = (state_r == FIN);

endmodule

// File: tb/tb_contador_secuencia_ctrl.sv
// Bench for contador_secuencia_ctrl: two instances (TICK_DIV=1 and 3) share
// clock, reset and stimulus. The reference model tracks elapsed run clocks and
// derives position, laps and pulses arithmetically from that count.
module tb_contador_secuencia_ctrl;
  localparam int LW = 4;

  logic C = 1'b0;
  logic R = 1'b1;
  always #5 C = ~C;

  contador_secuencia_ctrl_if #(.LAP_W(LW)) bus1 ();
  contador_secuencia_ctrl_if #(.LAP_W(LW)) bus3 ();

  contador_secuencia_ctrl #(.TICK_DIV(1), .LAP_W(LW)) u_dut1 (
    .C(C), .R(R), .bus(bus1)
  );
  contador_secuencia_ctrl #(.TICK_DIV(3), .LAP_W(LW)) u_dut3 (
    .C(C), .R(R), .bus(bus3)
  );

`ifdef CONTADOR_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int rom_tb[8] = '{7, 13, 7, 9, 6, 12, 2, 8};
  int td[2]     = '{1, 3};
  int ph[2];     // 0 idle, 1 run, 2 fin, 3 hold
  int t[2];      // run clocks elapsed (frozen while holding)
  int lreq[2];
  int lkeep[2];

  bit cur_start, cur_stop, cur_hold;
  int cur_laps;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit running(int d);
    return (ph[d] == 1) || (ph[d] == 3);
  endfunction

  function automatic int e_idx(int d);
    return running(d) ? (t[d] / td[d]) % 8 : 0;
  endfunction

  function automatic int e_lap(int d);
    if (running(d)) return (t[d] / (8 * td[d])) % (1 << LW);
    if (ph[d] == 2) return lreq[d];
    return lkeep[d];
  endfunction

  function automatic int e_wrap(int d);
    if (ph[d] != 1 || cur_stop || (PAUSE && cur_hold)) return 0;
    return ((t[d] + 1) % (8 * td[d]) == 0) ? 1 : 0;
  endfunction

  task automatic check_dut(input int d, input logic [3:0] q, input logic [2:0] ix,
                           input logic [LW-1:0] lc, input logic b, input logic w,
                           input logic dn);
    chk($sformatf("d%0d_Q", td[d]), 32'(q), rom_tb[e_idx(d)]);
    chk($sformatf("d%0d_idx", td[d]), 32'(ix), e_idx(d));
    chk($sformatf("d%0d_lap_cnt", td[d]), 32'(lc), e_lap(d));
    chk($sformatf("d%0d_busy", td[d]), 32'(b), running(d) ? 1 : 0);
    chk($sformatf("d%0d_wrap", td[d]), 32'(w), e_wrap(d));
    chk($sformatf("d%0d_done", td[d]), 32'(dn), (ph[d] == 2) ? 1 : 0);
  endtask

  task automatic model_edge(input int d);
    case (ph[d])
      0: if (cur_start) begin ph[d] = 1; t[d] = 0; lreq[d] = cur_laps; end
      1: begin
        if (cur_stop) begin lkeep[d] = e_lap(d); ph[d] = 0; end
        else if (PAUSE && cur_hold) ph[d] = 3;
        else begin
          t[d]++;
          if (lreq[d] != 0 && t[d] / (8 * td[d]) == lreq[d]) ph[d] = 2;
        end
      end
      2: begin ph[d] = 0; lkeep[d] = lreq[d]; end
      default: begin
        if (cur_stop) begin lkeep[d] = e_lap(d); ph[d] = 0; end
        else if (!cur_hold) ph[d] = 1;
      end
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; t[d] = 0; lreq[d] = 0; lkeep[d] = 0;
    end
  endtask

  task automatic step(input bit st, input int lp, input bit sp, input bit hd);
    @(negedge C);
    cur_start = st; cur_laps = lp; cur_stop = sp; cur_hold = hd;
    bus1.start = st; bus1.laps = LW'(lp); bus1.stop = sp; bus1.hold = hd;
    bus3.start = st; bus3.laps = LW'(lp); bus3.stop = sp; bus3.hold = hd;
    #1;
    check_dut(0, bus1.Q, bus1.idx, bus1.lap_cnt, bus1.busy, bus1.wrap, bus1.done);
    check_dut(1, bus3.Q, bus3.idx, bus3.lap_cnt, bus3.busy, bus3.wrap, bus3.done);
    @(posedge C);
    model_edge(0);
    model_edge(1);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  int wraps;

  initial begin
    model_reset();
    cur_start = 0; cur_stop = 0; cur_hold = 0; cur_laps = 0;
    bus1.start = 0; bus1.laps = '0; bus1.stop = 0; bus1.hold = 0;
    bus3.start = 0; bus3.laps = '0; bus3.stop = 0; bus3.hold = 0;
    repeat (3) @(posedge C);
    @(negedge C);
    R = 1'b0;

    // reset state
    idle_steps(2);

    // one lap: TICK_DIV=1 finishes after 8 steps, TICK_DIV=3 after 24
    step(1, 1, 0, 0);
    idle_steps(30);

    // two laps
    step(1, 2, 0, 0);
    idle_steps(56);
    #1;
    chk("laps2_lap_cnt", 32'(bus3.lap_cnt), 2);

    // free run then stop after 20 steps of the TICK_DIV=1 instance
    step(1, 0, 0, 0);
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      if (bus1.wrap === 1'b1) wraps++;
    end
    step(0, 0, 1, 0);
    #1;
    chk("stop_wraps_ge2", 32'(wraps >= 2), 1);
    chk("stop_lap_cnt", 32'(bus1.lap_cnt), 2);
    chk("stop_Q", 32'(bus1.Q), 7);
    chk("stop_busy", 32'(bus1.busy), 0);
    idle_steps(2);

    // start and stop together in IDLE starts a run; start while busy is ignored
    step(1, 2, 1, 0);
    idle_steps(3);
    step(1, 5, 0, 0);
    idle_steps(4);
    step(0, 0, 1, 0);
    idle_steps(2);

    // hold at Q=9 for five clocks
    step(1, 0, 0, 0);
    idle_steps(3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    #1;
    chk("hold_Q", 32'(bus1.Q), PAUSE ? 9 : 7);
    idle_steps(4);
    step(0, 0, 1, 0);
    idle_steps(1);

    // asynchronous reset in the middle of a run
    step(1, 3, 0, 0);
    idle_steps(6);
    @(negedge C);
    #2;
    R = 1'b1;
    #1;
    chk("arst_Q", 32'(bus1.Q), 7);
    chk("arst_idx", 32'(bus1.idx), 0);
    chk("arst_busy", 32'(bus1.busy), 0);
    chk("arst_done", 32'(bus1.done), 0);
    chk("arst_busy3", 32'(bus3.busy), 0);
    model_reset();
    @(negedge C);
    R = 1'b0;
    idle_steps(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(7) == 0), int'($urandom_range(3)),
           ($urandom_range(59) == 0), ($urandom_range(5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
